// File: rtl/bsk_pkg.sv
// Shared definitions for the BSK command path (also used by the PRD register block).
package bsk_pkg;

   localparam int COM_WIDTH    = 16;
   localparam int PRESC_DEF    = 250;
   localparam int FILT_LEN_DEF = 4;

   typedef logic [COM_WIDTH-1:0] com_t;

endpackage

// File: rtl/bsk_debounce_ch.sv
// One command channel: 2-FF synchroniser on the active-low raw line followed by a
// consecutive-sample filter that advances only on prescaler ticks.
module bsk_debounce_ch
   import bsk_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic srst_i,
   input  logic tick_i,
   input  logic com_n_i,
   output logic com_o,
   output logic change_o
);

   localparam int CW = $clog2(FILT_LEN);

   logic          sync1_q;
   logic          sync2_q;
   logic          com_q;
   logic          com_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          sample;

   assign sample = ~sync2_q;

   // A sample equal to the accepted level restarts the count: no integration.
   always_comb begin
      cnt_d    = cnt_q;
      com_d    = com_q;
      change_o = 1'b0;
      if (tick_i) begin
         if (sample == com_q) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(FILT_LEN - 1)) begin
            com_d    = sample;
            cnt_d    = '0;
            change_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         com_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= com_n_i;
         sync2_q <= sync1_q;
         com_q   <= com_d;
         cnt_q   <= cnt_d;
      end
   end

   assign com_o = com_q;

endmodule

// File: rtl/bsk_com_filter.sv
// Command input conditioning: per-channel debounce, shared sample-tick prescaler,
// window-valid status and change pulse / sticky change mask for the bus side.
module bsk_com_filter
   import bsk_pkg::*;
#(
   parameter int WIDTH    = COM_WIDTH,
   parameter int PRESC    = PRESC_DEF,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic             clk,
   input  logic             iRes,
   input  logic [WIDTH-1:0] iCom,
   input  logic             iAck,
   output logic [WIDTH-1:0] oCom,
   output logic             oValid,
   output logic             oChg,
   output logic [WIDTH-1:0] oChgMask
);

   localparam int PW = $clog2(PRESC + 1);
   localparam int TW = $clog2(FILT_LEN);

   logic [PW-1:0]    presc_q;
   logic [PW-1:0]    presc_d;
   logic             tick;
   logic [TW-1:0]    tcnt_q;
   logic [TW-1:0]    tcnt_d;
   logic             valid_q;
   logic             valid_d;
   logic             chg_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic [WIDTH-1:0] change;

   assign tick    = (presc_q == PW'(PRESC - 1));
   assign presc_d = tick ? '0 : presc_q + 1'b1;

   // oValid marks the end of the first complete filter window after reset.
   always_comb begin
      tcnt_d  = tcnt_q;
      valid_d = valid_q;
      if (tick && !valid_q) begin
         if (tcnt_q == TW'(FILT_LEN - 1)) begin
            valid_d = 1'b1;
         end else begin
            tcnt_d = tcnt_q + 1'b1;
         end
      end
   end

   // Acceptances coinciding with iAck survive the clear.
   assign mask_d = iAck ? change : (mask_q | change);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
         bsk_debounce_ch #(
            .FILT_LEN (FILT_LEN)
         ) u_ch (
            .clk      (clk),
            .srst_i   (iRes),
            .tick_i   (tick),
            .com_n_i  (iCom[gi]),
            .com_o    (oCom[gi]),
            .change_o (change[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (iRes) begin
         presc_q <= '0;
         tcnt_q  <= '0;
         valid_q <= 1'b0;
         chg_q   <= 1'b0;
         mask_q  <= '0;
      end else begin
         presc_q <= presc_d;
         tcnt_q  <= tcnt_d;
         valid_q <= valid_d;
         chg_q   <= |change;
         mask_q  <= mask_d;
      end
   end

   assign oValid   = valid_q;
   assign oChg     = chg_q;
   assign oChgMask = mask_q;

endmodule
